tetromino_address_gen: RTL and testbench
========================================

Name: tetromino_address_gen

Overview:
Pseudo-random tetromino selector for FPGA_Tetris. A free-running maximal-length Fibonacci LFSR (PRBS) produces a 3-bit shape address in the range 0..6 on every pixel clock. The address drives the BRAM read address of the tetromino shape ROM that holds all block definitions. Code 7 is never emitted.

Parameters:
LFSR_WIDTH, 16, LFSR register width in bits; minimum 4.
TAPS, 16'hB400, feedback tap mask: bits 15, 13, 12 and 10, giving x^16+x^14+x^13+x^11+1 (maximal length).
SEED, 16'hACE1, LFSR value loaded on reset; must be non-zero.
NUM_SHAPES, 7, number of valid addresses (0..NUM_SHAPES-1); fixed at 7 for the 3-bit output.

Ports:
i_pixclk  input  1  pixel clock; the only clock; all state is rising-edge.
i_reset_n  input  1  asynchronous active-low reset.
o_tetromino_address  output  3  registered shape address, 0..6.

Behaviour:
- Reset: asynchronous assert, synchronous release. While i_reset_n=0: lfsr=SEED and o_tetromino_address=3'd0.
- LFSR update each rising edge when out of reset:
  - fb = XOR-reduce(lfsr & TAPS)
  - lfsr <= {lfsr[LFSR_WIDTH-2:0], fb}
- Lock-up guard: if lfsr is all-zero (corruption, or a SEED=0 misconfiguration), the next value is 1 instead of the shift result.
- Candidate address = lfsr[2:0], taken from the current (pre-shift) LFSR value.
- Output register, updated on the same edge:
  - if candidate != 7: o_tetromino_address <= candidate
  - else: hold the previous value (rejection; no extra cycle)
- Latency: the first edge after reset release loads lfsr[2:0] of SEED. For the default SEED this gives 1.
- o_tetromino_address never equals 7, in any cycle including reset.
- No enable or request input. Consumers sample the output whenever they need a new piece; because the output changes every cycle, the sample time provides the randomness.
- Period: the LFSR sequence repeats every 2^16-1 cycles. Over a full period, codes 0..6 each appear as a fresh (non-held) update 8192 times, except 0, which appears 8191 times.
- Reset mid-operation: asynchronous return to SEED/0 within the same cycle. After release the sequence restarts identically (deterministic).

Decomposition:
- Shared package tetris_pkg:
  - constant NUM_SHAPES = 7
  - 3-bit shape codes: I=0, O=1, T=2, S=3, Z=4, J=5, L=6
  - default LFSR constants: TAPS, SEED
- One sub-module, prbs_lfsr: parameterised LFSR_WIDTH/TAPS/SEED, with async active-low reset, zero-lock guard and full-state output.
- The top level adds only the rejection and output register.

Test Plan:
- Reset: clock running, i_reset_n high 20 ns, low 10 ns, then high -> output 0 during reset; internal lfsr=16'hACE1.
- Sequence after release, first five edges -> o_tetromino_address = 1, 3, 3, 3, 6. Internal lfsr = 59C3, B387, 670F, CE1E, then next. The two middle 3s are holds from candidate 7.
- Range: run 2^16 cycles after reset -> output never 7; every code 0..6 observed; lfsr returns to 16'hACE1 after exactly 65535 edges.
- Asynchronous reset mid-run: assert i_reset_n between clock edges at cycle 1000 -> output goes to 0 immediately, without waiting for a clock edge. After release, the sequence repeats 1, 3, 3, 3, 6.
- Distribution: count fresh (non-held) updates over one full period -> 8192 per code for 1..6, 8191 for 0.
- Lock-up guard: force lfsr to 0 for one cycle -> the next lfsr is 1 and the output continues to update validly.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants for the tetromino selector: shape codes and default PRBS settings.
package tetris_pkg;

  localparam int NUM_SHAPES = 7;

  typedef enum logic [2:0] {
    SHAPE_I = 3'd0,
    SHAPE_O = 3'd1,
    SHAPE_T = 3'd2,
    SHAPE_S = 3'd3,
    SHAPE_Z = 3'd4,
    SHAPE_J = 3'd5,
    SHAPE_L = 3'd6
  } shape_e;

  // The one 3-bit code with no ROM entry; candidates equal to it are dropped.
  localparam logic [2:0] SHAPE_REJECT = 3'(NUM_SHAPES);

  localparam int          LFSR_WIDTH_DEF = 16;
  localparam logic [15:0] LFSR_TAPS_DEF  = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;

  function automatic logic shape_valid(input logic [2:0] code);
    return code != SHAPE_REJECT;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Free-running Fibonacci LFSR with a zero-state escape; exposes the full state.
module prbs_lfsr
  import tetris_pkg::*;
#(
  parameter int                    LFSR_WIDTH = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_TAPS_DEF,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_SEED_DEF
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  output logic [LFSR_WIDTH-1:0] state
);

  localparam logic [LFSR_WIDTH-1:0] ONE = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

  logic                  fb;
  logic [LFSR_WIDTH-1:0] state_nxt;

  always_comb begin
    fb        = ^(state & TAPS);
    state_nxt = {state[LFSR_WIDTH-2:0], fb};
    // All-zero is a fixed point of the shift; kick it back onto the sequence.
    if (state == '0) state_nxt = ONE;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state <= SEED;
    else         state <= state_nxt;
  end

endmodule

// File: rtl/tetromino_address_gen.sv
// Shape ROM address source: low LFSR bits, code 7 rejected by holding the last address.
module tetromino_address_gen
  import tetris_pkg::*;
#(
  parameter int                    LFSR_WIDTH = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_TAPS_DEF,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_SEED_DEF
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  output logic [2:0] o_tetromino_address
);

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [2:0]            cand;
  logic                  lfsr_unused;

  prbs_lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .TAPS       (TAPS),
    .SEED       (SEED)
  ) u_lfsr (
    .gclk   (i_pixclk),
    .grst_n (i_reset_n),
    .state  (lfsr_q)
  );

  assign cand        = lfsr_q[2:0];
  assign lfsr_unused = ^lfsr_q[LFSR_WIDTH-1:3];

  // Candidate comes from the pre-shift state, so address and LFSR move on the same edge.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n)             o_tetromino_address <= SHAPE_I;
    else if (shape_valid(cand)) o_tetromino_address <= cand;
  end

endmodule

// File: tb/tb_tetromino_address_gen.sv
// Bench for tetromino_address_gen: per-cycle model compare plus literal sequence/period/distribution pins.
module tb_tetromino_address_gen;

  logic       clk;
  logic       rst_n;
  logic [2:0] out_a;
  logic [2:0] out_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  tetromino_address_gen u_dut (
    .i_pixclk            (clk),
    .i_reset_n           (rst_n),
    .o_tetromino_address (out_a)
  );

  // Zero seed exercises the lock-up escape from the very first edge.
  tetromino_address_gen #(.SEED(16'h0000)) u_dut0 (
    .i_pixclk            (clk),
    .i_reset_n           (rst_n),
    .o_tetromino_address (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 in Fibonacci form: parity of bits 15,13,12,10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int  tap_pos [4] = '{15, 13, 12, 10};
    bit  p = 1'b0;
    if (s == 16'h0) return 16'h0001;
    foreach (tap_pos[i]) p = p ^ s[tap_pos[i]];
    return {s[14:0], p};
  endfunction

  logic [15:0] ma, mb;
  logic [2:0]  oa, ob;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= 16'hACE1; oa <= 3'd0;
      mb <= 16'h0000; ob <= 3'd0;
    end else begin
      ma <= lfsr_next(ma);
      mb <= lfsr_next(mb);
      if (ma[2:0] != 3'd7) oa <= ma[2:0];
      if (mb[2:0] != 3'd7) ob <= mb[2:0];
    end
  end

  bit seen [7];

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_a_model",  {29'd0, out_a}, {29'd0, oa});
      check("lfsr_a_model", {16'd0, u_dut.lfsr_q}, {16'd0, ma});
      check("out_b_model",  {29'd0, out_b}, {29'd0, ob});
      check("lfsr_b_model", {16'd0, u_dut0.lfsr_q}, {16'd0, mb});
      check("out_a_not7",   {31'd0, out_a == 3'd7}, 32'd0);
      check("out_b_not7",   {31'd0, out_b == 3'd7}, 32'd0);
      if (out_a != 3'd7) seen[out_a] = 1'b1;
    end
  end

  logic [2:0]  exp_out [5] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd6};
  logic [15:0] exp_lfsr[5] = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E, 16'h9C3C};
  logic [2:0]  exp_ob  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
  logic [15:0] exp_lb  [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};

  task automatic check_first_five(input string tag);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_seq_out"},  {29'd0, out_a}, {29'd0, exp_out[k]});
      check({tag, "_seq_lfsr"}, {16'd0, u_dut.lfsr_q}, {16'd0, exp_lfsr[k]});
    end
  endtask

  int fresh [7];
  int first_return;
  logic [2:0] c;

  initial begin
    rst_n = 1'b1;
    foreach (fresh[i]) fresh[i] = 0;
    first_return = -1;
    #20 rst_n = 1'b0;
    #7  mon_en = 1'b1;
    check("reset_out_a",  {29'd0, out_a}, 32'd0);
    check("reset_lfsr_a", {16'd0, u_dut.lfsr_q}, 32'h0000ACE1);
    check("reset_out_b",  {29'd0, out_b}, 32'd0);
    check("reset_lfsr_b", {16'd0, u_dut0.lfsr_q}, 32'd0);
    #3 rst_n = 1'b1;

    // One full period: edge j leaves state j; states 1..65535 cover the whole cycle once.
    for (int j = 1; j <= 65535; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j <= 5) begin
        check("seq_out",    {29'd0, out_a}, {29'd0, exp_out[j-1]});
        check("seq_lfsr",   {16'd0, u_dut.lfsr_q}, {16'd0, exp_lfsr[j-1]});
        check("guard_out",  {29'd0, out_b}, {29'd0, exp_ob[j-1]});
        check("guard_lfsr", {16'd0, u_dut0.lfsr_q}, {16'd0, exp_lb[j-1]});
      end
      c = u_dut.lfsr_q[2:0];
      if (c != 3'd7) fresh[c]++;
      if (first_return < 0 && u_dut.lfsr_q == 16'hACE1) first_return = j;
    end
    check("period_first_return", first_return, 32'd65535);
    check("period_lfsr", {16'd0, u_dut.lfsr_q}, 32'h0000ACE1);
    check("dist_code0", fresh[0], 32'd8191);
    for (int k = 1; k < 7; k++) check("dist_code", fresh[k], 32'd8192);
    for (int k = 0; k < 7; k++) check("code_seen", {31'd0, seen[k]}, 32'd1);

    // Asynchronous reset between edges, then deterministic restart.
    repeat (1000) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out",  {29'd0, out_a}, 32'd0);
    check("async_rst_lfsr", {16'd0, u_dut.lfsr_q}, 32'h0000ACE1);
    #3 rst_n = 1'b1;
    check_first_five("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
